// File: rtl/sd_sched_pkg.sv
// Shared types, SD block register map and helpers for the SD block scheduler.
package sd_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_FILL,
    S_SET_ADDR,
    S_KICK,
    S_SETTLE,
    S_POLL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] SD_REG_ADDR  = 16'h1000;
  localparam logic [15:0] SD_REG_RD    = 16'h1004;
  localparam logic [15:0] SD_REG_WR    = 16'h1008;
  localparam logic [15:0] SD_REG_READY = 16'h2010;
  localparam int unsigned SD_CACHE_WORDS = 128;
  localparam int unsigned IDX_W = 7;
  localparam logic [31:0] SD_KICK_VAL = 32'h0100_0000;

  // The SD block byte-swaps register writes, so register values are pre-swapped.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sd_block_sched_rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer advances when a grant completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       grant
);

  logic r_last;

  // On contention favour the client not served last; otherwise the lone requester.
  assign grant = (req == 2'b11) ? ~r_last : req[1];

  always_ff @(posedge clk) begin
    if (rst)          r_last <= 1'b1;
    else if (advance) r_last <= served;
  end

endmodule

// File: rtl/sd_block_sched.sv
// Round-robin whole-sector scheduler driving the SD block memory port.
// Optional ready-poll timeout enabled with `define SD_SCHED_TIMEOUT_EN.
module sd_block_sched
  import sd_sched_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  wr,
  input  logic [31:0] lba0,
  input  logic [31:0] lba1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [6:0]  widx,
  output logic [31:0] rdata,
  output logic [1:0]  rvalid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic        owner,
  output logic [15:0] sd_a,
  output logic [31:0] sd_d,
  output logic        sd_we,
  input  logic [31:0] sd_spo
);

  state_t             r_state, w_state_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_wr, w_wr_nxt;
  logic [31:0]        r_lba, w_lba_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_widx, w_widx_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic [1:0]         r_rvalid, w_rvalid_nxt;
  logic [1:0]         r_done, w_done_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic               r_busy, w_busy_nxt;
  logic [15:0]        r_sd_a, w_sd_a_nxt;
  logic [31:0]        r_sd_d, w_sd_d_nxt;
  logic               r_sd_we, w_sd_we_nxt;
  logic               w_grant;
  logic               w_tmo_hit;
  logic [31:0]        w_wdata;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (r_state == S_DONE),
    .served  (r_owner),
    .grant   (w_grant)
  );

`ifdef SD_SCHED_TIMEOUT_EN
  logic [23:0] r_tmo;

  assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 24'd1);

  // Restarts on every state change, so it measures time spent in the current wait.
  always_ff @(posedge clk) begin
    if (rst)                                             r_tmo <= '0;
    else if (w_state_nxt != r_state)                     r_tmo <= '0;
    else if (r_state == S_WAIT_RDY || r_state == S_POLL) r_tmo <= r_tmo + 24'd1;
  end
`else
  logic w_unused;
  assign w_tmo_hit = 1'b0;
  assign w_unused  = ^TIMEOUT_CYCLES;
`endif

  assign w_wdata = r_owner ? wdata1 : wdata0;

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_wr_nxt     = r_wr;
    w_lba_nxt    = r_lba;
    w_cnt_nxt    = r_cnt;
    w_widx_nxt   = r_widx;
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = '0;
    w_done_nxt   = '0;
    w_err_nxt    = '0;
    w_sd_a_nxt   = r_sd_a;
    w_sd_d_nxt   = r_sd_d;
    w_sd_we_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_grant;
          w_wr_nxt    = wr[w_grant];
          w_lba_nxt   = w_grant ? lba1 : lba0;
          w_widx_nxt  = '0;
          w_sd_a_nxt  = SD_REG_READY;
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (sd_spo[0]) begin
          if (r_wr) begin
            // widx runs one word ahead so sd_d can be registered from wdata.
            w_sd_a_nxt  = 16'({r_widx, 2'b00});
            w_sd_d_nxt  = w_wdata;
            w_sd_we_nxt = 1'b1;
            w_widx_nxt  = r_widx + 7'd1;
            w_state_nxt = S_FILL;
          end else begin
            w_sd_a_nxt  = SD_REG_ADDR;
            w_sd_d_nxt  = bswap32(r_lba);
            w_sd_we_nxt = 1'b1;
            w_state_nxt = S_SET_ADDR;
          end
        end else if (w_tmo_hit) begin
          w_done_nxt[r_owner] = 1'b1;
          w_err_nxt[r_owner]  = 1'b1;
          w_state_nxt         = S_DONE;
        end
      end
      S_FILL: begin
        if (r_sd_a[8:2] == 7'd127) begin
          w_sd_a_nxt  = SD_REG_ADDR;
          w_sd_d_nxt  = bswap32(r_lba);
          w_sd_we_nxt = 1'b1;
          w_state_nxt = S_SET_ADDR;
        end else begin
          w_sd_a_nxt  = 16'({r_widx, 2'b00});
          w_sd_d_nxt  = w_wdata;
          w_sd_we_nxt = 1'b1;
          w_widx_nxt  = r_widx + 7'd1;
        end
      end
      S_SET_ADDR: begin
        w_sd_a_nxt  = r_wr ? SD_REG_WR : SD_REG_RD;
        w_sd_d_nxt  = SD_KICK_VAL;
        w_sd_we_nxt = 1'b1;
        w_state_nxt = S_KICK;
      end
      S_KICK: begin
        w_sd_a_nxt  = SD_REG_READY;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'd1) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        if (sd_spo[0]) begin
          if (r_wr) begin
            w_done_nxt[r_owner] = 1'b1;
            w_state_nxt         = S_DONE;
          end else begin
            w_sd_a_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end
        end else if (w_tmo_hit) begin
          w_done_nxt[r_owner] = 1'b1;
          w_err_nxt[r_owner]  = 1'b1;
          w_state_nxt         = S_DONE;
        end
      end
      S_DRAIN: begin
        // One extra pass after the last address lets the final rvalid go out.
        if (r_cnt < 8'(SD_CACHE_WORDS)) begin
          w_rdata_nxt           = sd_spo;
          w_rvalid_nxt[r_owner] = 1'b1;
          w_widx_nxt            = r_cnt[6:0];
          w_sd_a_nxt            = 16'({r_cnt[6:0] + 7'd1, 2'b00});
          w_cnt_nxt             = r_cnt + 8'd1;
        end else begin
          w_done_nxt[r_owner] = 1'b1;
          w_state_nxt         = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_wr     <= 1'b0;
      r_lba    <= '0;
      r_cnt    <= '0;
      r_widx   <= '0;
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      r_sd_a   <= '0;
      r_sd_d   <= '0;
      r_sd_we  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_wr     <= w_wr_nxt;
      r_lba    <= w_lba_nxt;
      r_cnt    <= w_cnt_nxt;
      r_widx   <= w_widx_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_sd_a   <= w_sd_a_nxt;
      r_sd_d   <= w_sd_d_nxt;
      r_sd_we  <= w_sd_we_nxt;
    end
  end

  assign widx   = r_widx;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign done   = r_done;
  assign err    = r_err;
  assign busy   = r_busy;
  assign owner  = r_owner;
  assign sd_a   = r_sd_a;
  assign sd_d   = r_sd_d;
  assign sd_we  = r_sd_we;

endmodule

// File: tb/tb_sd_block_sched.sv
// Directed bench for sd_block_sched with a behavioural SD block (cache + ready register).
module tb_sd_block_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wr;
  logic [31:0] lba0, lba1, wdata0, wdata1;
  logic [6:0]  widx;
  logic [31:0] rdata;
  logic [1:0]  rvalid, done, err;
  logic        busy, owner;
  logic [15:0] sd_a;
  logic [31:0] sd_d;
  logic        sd_we;
  logic [31:0] sd_spo;

  int checks = 0;
  int failures = 0;

  sd_block_sched #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .lba0(lba0), .lba1(lba1),
    .wdata0(wdata0), .wdata1(wdata1), .widx(widx), .rdata(rdata), .rvalid(rvalid),
    .done(done), .err(err), .busy(busy), .owner(owner), .sd_a(sd_a), .sd_d(sd_d),
    .sd_we(sd_we), .sd_spo(sd_spo)
  );

  always #5 clk = ~clk;

  assign wdata0 = 32'h5A00_0000 + 32'(widx);
  assign wdata1 = 32'hA500_0000 + 32'(widx);

  // SD block model
  logic [31:0] cache [128];
  bit          init_done = 1'b0;
  logic        m_ready;
  int          m_hold;
  int          ready_delay;
  bit          stuck;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) cache[i] <= 32'hC0DE_0000 + 32'(i);
      init_done <= 1'b1;
    end else if (!rst && sd_we && sd_a < 16'h0200) begin
      cache[sd_a[8:2]] <= sd_d;
    end
    if (rst) begin
      m_ready <= 1'b1;
      m_hold  <= 0;
    end else if (sd_we && (sd_a == 16'h1004 || sd_a == 16'h1008)) begin
      m_ready <= 1'b0;
      m_hold  <= ready_delay;
    end else if (!m_ready && !stuck) begin
      if (m_hold == 0) m_ready <= 1'b1;
      else             m_hold <= m_hold - 1;
    end
  end

  always_comb begin
    if (sd_a == 16'h2010)     sd_spo = {31'd0, m_ready};
    else if (sd_a < 16'h0200) sd_spo = cache[sd_a[8:2]];
    else                      sd_spo = 32'h0;
  end

  // Port monitor: records SD writes and checks the read-word stream.
  int          fill_cnt = 0, fill_bad = 0, rv0_cnt = 0, rv1_cnt = 0, rv_bad = 0;
  logic [6:0]  fill_idx, ridx0, ridx1;
  logic [31:0] lba_wr = '0, kick_d = '0;
  logic [15:0] kick_a = '0;
  int          kick_cyc = 0, first_rv_cyc = 0, last_rv_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      fill_idx = '0;
      ridx0 = '0;
      ridx1 = '0;
    end else begin
      if (sd_we) begin
        if (sd_a < 16'h0200) begin
          fill_cnt++;
          if (sd_a[8:2] != fill_idx || sd_d != 32'hA500_0000 + 32'(fill_idx)) fill_bad++;
          fill_idx++;
        end else if (sd_a == 16'h1000) begin
          lba_wr = sd_d;
        end else if (sd_a == 16'h1004 || sd_a == 16'h1008) begin
          kick_a = sd_a;
          kick_d = sd_d;
          kick_cyc = cyc;
        end
      end
      if (rvalid[0]) begin
        rv0_cnt++;
        if (widx != ridx0 || rdata !== cache[widx]) rv_bad++;
        ridx0++;
      end
      if (rvalid[1]) begin
        rv1_cnt++;
        if (widx != ridx1 || rdata !== cache[widx]) rv_bad++;
        ridx1++;
      end
      if (|rvalid) begin
        if (widx == 7'd0) first_rv_cyc = cyc;
        last_rv_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  int         ord [2];
  logic [1:0] done_err;
  int         dcyc;

  // Waits for n completions, dropping each finisher's req as its done pulses.
  task automatic run_until(input int n, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (done[0]) begin ord[seen] = 0; done_err = err; dcyc = cyc; req[0] = 1'b0; seen++; end
      else if (done[1]) begin ord[seen] = 1; done_err = err; dcyc = cyc; req[1] = 1'b0; seen++; end
    end
    chk("done_count_in_budget", 32'(seen), 32'(n));
  endtask

  int s_rv0, s_rv1, s_bad, s_fill, s_fbad;
  bit found;

  initial begin
    rst = 1'b1; req = '0; wr = '0; lba0 = '0; lba1 = '0;
    ready_delay = 3; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sd_a", 32'(sd_a), 32'h0);
    chk("rst_sd_d", sd_d, 32'h0);
    chk("rst_ctl", 32'({sd_we, rvalid, done, err, busy, owner}), 32'h0);
    chk("rst_widx", 32'(widx), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, client 0
    s_rv0 = rv0_cnt; s_rv1 = rv1_cnt; s_bad = rv_bad;
    lba0 = 32'h0000_0010; wr[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    chk("rd_busy", 32'(busy), 32'h1);
    chk("rd_owner", 32'(owner), 32'h0);
    run_until(1, 600);
    chk("rd_done_client", 32'(ord[0]), 32'h0);
    chk("rd_lba_reg", lba_wr, 32'h1000_0000);
    chk("rd_kick_addr", 32'(kick_a), 32'h1004);
    chk("rd_kick_data", kick_d, 32'h0100_0000);
    chk("rd_rvalid0_count", 32'(rv0_cnt - s_rv0), 32'd128);
    chk("rd_rvalid1_count", 32'(rv1_cnt - s_rv1), 32'd0);
    chk("rd_word_errors", 32'(rv_bad - s_bad), 32'd0);
    chk("rd_err", 32'(done_err), 32'h0);
    chk("rd_first_rvalid_lat", 32'(first_rv_cyc - kick_cyc), 32'd7);
    chk("rd_done_after_tail", 32'(dcyc - last_rv_cyc), 32'd1);
    @(negedge clk);
    chk("rd_idle_busy", 32'(busy), 32'h0);

    // Single write, client 1
    s_fill = fill_cnt; s_fbad = fill_bad; s_rv0 = rv0_cnt; s_rv1 = rv1_cnt;
    lba1 = 32'h0012_3456; wr[1] = 1'b1; req[1] = 1'b1;
    @(negedge clk);
    chk("wr_owner", 32'(owner), 32'h1);
    run_until(1, 800);
    chk("wr_done_client", 32'(ord[0]), 32'h1);
    chk("wr_fill_count", 32'(fill_cnt - s_fill), 32'd128);
    chk("wr_fill_errors", 32'(fill_bad - s_fbad), 32'd0);
    chk("wr_lba_reg", lba_wr, 32'h5634_1200);
    chk("wr_kick_addr", 32'(kick_a), 32'h1008);
    chk("wr_kick_data", kick_d, 32'h0100_0000);
    chk("wr_done_lat", 32'(dcyc - kick_cyc), 32'd6);
    chk("wr_no_rvalid", 32'((rv0_cnt - s_rv0) + (rv1_cnt - s_rv1)), 32'd0);
    chk("wr_err", 32'(done_err), 32'h0);
    @(negedge clk);

    // Simultaneous reads, twice
    wr = 2'b00; lba0 = 32'h0000_0001; lba1 = 32'h0000_0002;
    for (int p = 0; p < 2; p++) begin
      s_rv0 = rv0_cnt; s_rv1 = rv1_cnt; s_bad = rv_bad;
      req = 2'b11;
      run_until(2, 1500);
      chk("pair_first", 32'(ord[0]), 32'h0);
      chk("pair_second", 32'(ord[1]), 32'h1);
      chk("pair_rv0", 32'(rv0_cnt - s_rv0), 32'd128);
      chk("pair_rv1", 32'(rv1_cnt - s_rv1), 32'd128);
      chk("pair_word_errors", 32'(rv_bad - s_bad), 32'd0);
      @(negedge clk);
    end

    // Ready held low for 50 cycles after the kick
    ready_delay = 49;
    s_rv0 = rv0_cnt; s_bad = rv_bad;
    req[0] = 1'b1;
    run_until(1, 800);
    chk("slow_first_rvalid_lat", 32'(first_rv_cyc - kick_cyc), 32'd53);
    chk("slow_rv0", 32'(rv0_cnt - s_rv0), 32'd128);
    chk("slow_word_errors", 32'(rv_bad - s_bad), 32'd0);
    chk("slow_err", 32'(done_err), 32'h0);
    ready_delay = 3;
    @(negedge clk);

`ifdef SD_SCHED_TIMEOUT_EN
    // Ready stuck low: timeout after 100 POLL cycles
    stuck = 1'b1;
    s_rv0 = rv0_cnt;
    req[0] = 1'b1;
    run_until(1, 800);
    chk("tmo_err", 32'(done_err), 32'h1);
    chk("tmo_lat", 32'(dcyc - kick_cyc), 32'd103);
    chk("tmo_no_rvalid", 32'(rv0_cnt - s_rv0), 32'd0);
    stuck = 1'b0;
    repeat (10) @(negedge clk);
`endif

    // Reset in the middle of DRAIN
    req[0] = 1'b1; wr[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge clk);
      if (rvalid[0] && widx == 7'd40) found = 1'b1;
    end
    chk("abort_reached_idx40", 32'(found), 32'h1);
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("abort_sd_a", 32'(sd_a), 32'h0);
    chk("abort_sd_d", sd_d, 32'h0);
    chk("abort_ctl", 32'({sd_we, rvalid, done, err, busy, owner}), 32'h0);
    chk("abort_widx", 32'(widx), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    s_rv1 = rv1_cnt; s_bad = rv_bad;
    wr[1] = 1'b0; req[1] = 1'b1;
    run_until(1, 600);
    chk("post_abort_client", 32'(ord[0]), 32'h1);
    chk("post_abort_rv1", 32'(rv1_cnt - s_rv1), 32'd128);
    chk("post_abort_word_errors", 32'(rv_bad - s_bad), 32'd0);
    chk("post_abort_err", 32'(done_err), 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_block_sched.md
# sd_block_sched

Two-requester block scheduler for the memory-mapped SPI SD card controller. Accepts whole-sector read/write requests from two clients, for example the CPU bootloader path and a DMA/disk engine. It arbitrates between them round-robin and drives the SD card's 128-word cache and control registers through that block's memory port. It sits between the clients and the SD card block and is the only master of that port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'hFFFFFF, ready-poll limit; used only with timeout compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  2  per-client request; held high until done
- wr  in  2  per-client: 1 = sector write, 0 = sector read; stable while req
- lba0, lba1  in  32  per-client sector address; stable while req
- wdata0, wdata1  in  32  per-client write word for index widx; combinational response
- widx  out  7  word index being filled or drained
- rdata  out  32  read word, valid with rvalid
- rvalid  out  2  per-client read-word strobe
- done  out  2  per-client one-cycle completion pulse
- err  out  2  per-client error, coincident with done
- busy  out  1  request in progress
- owner  out  1  granted client
- sd_a  out  16  SD block byte address
- sd_d  out  32  SD block write data
- sd_we  out  1  SD block write enable
- sd_spo  in  32  SD block read data; combinational on sd_a

## Operation
- States: IDLE, WAIT_RDY, FILL, SET_ADDR, KICK, SETTLE, POLL, DRAIN, DONE.
- IDLE: if any req is high, grant it.
  - If both are high, grant the client not served last.
  - The last-served pointer resets to 1, so client 0 wins first.
  - Latch owner, wr and lba, then go to WAIT_RDY.
- WAIT_RDY:
  - sd_a=0x2010, sd_we=0.
  - Leave when sd_spo[0]=1: to FILL if writing, SET_ADDR if reading.
- FILL:
  - sd_a={widx,2'b00}, sd_d=wdata[owner] raw with no byte swap, sd_we=1.
  - widx counts 0..127, then go to SET_ADDR.
- SET_ADDR:
  - sd_a=0x1000, sd_we=1.
  - sd_d = byte-swapped lba, i.e. {lba[7:0],lba[15:8],lba[23:16],lba[31:24]}, because the SD block byte-swaps register writes.
- KICK:
  - sd_a=0x1004 for read, 0x1008 for write.
  - sd_d=0x01000000 (swapped 1), sd_we=1.
- SETTLE: 2 cycles with sd_we=0, so the SD block's ready deasserts.
- POLL: sd_a=0x2010 until sd_spo[0]=1, then DRAIN if reading, DONE if writing.
- DRAIN:
  - sd_a={idx,2'b00} for idx 0..127.
  - Register sd_spo into rdata.
  - Pulse rvalid[owner] one cycle later with widx=that index: 128 consecutive pulses.
- DONE:
  - done[owner]=1 for one cycle; update the last-served pointer; go to IDLE.
  - A client still holding req the next cycle is treated as a new request.
- sd_we is low in every state not listed as asserting it.
- A req dropped mid-operation is ignored; the operation completes.

## Timing
- Reset values: sd_a=0, sd_d=0, sd_we=0, widx=0, rdata=0, rvalid=0, done=0, err=0, busy=0, owner=0; state IDLE.
- Reset mid-operation aborts immediately; the SD block shares rst.
- Grant: the cycle after req is seen in IDLE; busy is high from WAIT_RDY through DONE.
- Read latency from grant with ready already high: 1 (WAIT_RDY) + 1 + 1 + 2 + N_poll + 128 + 1 (rvalid tail) + 1 (DONE).
- Write latency from grant: 1 + 128 + 1 + 1 + 2 + N_poll + 1.
- widx wraps only at the state boundary; there is no carry into other fields.

## Configuration
- SD_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_RDY and POLL; it resets on entering each.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err[owner]=1; no DRAIN and no further SD writes.
- Undefined: polling is unbounded; err is tied 0.

## Structure
- Package sd_sched_pkg holds:
  - the state enum;
  - SD_REG_ADDR=16'h1000, SD_REG_RD=16'h1004, SD_REG_WR=16'h1008, SD_REG_READY=16'h2010, SD_CACHE_WORDS=128;
  - the byte-swap function.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a last-served pointer and an advance input pulsed in DONE.

## Test plan
- Single read, client 0, lba=0x00000010, ready model high:
  - expect writes 0x1000←0x10000000 and 0x1004←0x01000000;
  - then 128 rvalid[0] pulses with widx 0..127 matching the model's cache;
  - then done[0].
- Single write, client 1, wdata=0xA5000000+widx:
  - expect 128 cache writes at 0x000..0x1FC with raw data;
  - then 0x1008←0x01000000, POLL, done[1].
- Both req rise the same cycle, twice:
  - grant order 0,1 on the first pair;
  - a second simultaneous pair after serving 1 grants 0 then 1.
- Ready held low 50 cycles after KICK: no DRAIN starts until sd_spo[0] goes high; the operation then completes normally.
- With SD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, ready stuck low:
  - done[0] and err[0] in the same cycle after 100 POLL cycles;
  - zero rvalid pulses.
- rst asserted at DRAIN widx=40: next cycle all outputs are at reset values; a subsequent request completes cleanly.
